// File: rtl/commit_buffer.sv
// commit_buffer: in-order retirement of CDB results as single register-file write pulses
module commit_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   alloc_valid,
  input  logic [TAG_W-1:0]       alloc_tag,
  input  logic [4:0]             alloc_rd,
  output logic                   alloc_ready,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [31:0]            cdb_data,
  output logic                   commit_valid,
  output logic [4:0]             commit_addr,
  output logic [31:0]            commit_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DEPTH-1:0] busy, ready;
  logic [TAG_W-1:0] tag_q  [DEPTH];
  logic [4:0]       rd_q   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PW-1:0]    head, tail;
  logic             alloc_acc, retire;
  assign full        = count == CW'(DEPTH);
  assign empty       = count == '0;
  assign alloc_ready = !full;
  assign alloc_acc   = alloc_valid && !full;
  assign retire      = busy[head] && ready[head];
  // capture broadcasts, allocate at tail, retire the head once its result is in
  always_ff @(posedge clk) begin
    if (reset) begin
      busy         <= '0;
      ready        <= '0;
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      commit_valid <= 1'b0;
      commit_addr  <= '0;
      commit_data  <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (cdb_valid && busy[i] && !ready[i] && tag_q[i] == cdb_tag) begin
          ready[i]  <= 1'b1;
          data_q[i] <= cdb_data;
        end
      if (alloc_acc) begin
        busy[tail]  <= 1'b1;
        ready[tail] <= 1'b0;
        tag_q[tail] <= alloc_tag;
        rd_q[tail]  <= alloc_rd;
        tail        <= tail + 1'b1;
      end
      commit_valid <= retire && rd_q[head] != '0;
      if (retire) begin
        busy[head] <= 1'b0;
        head       <= head + 1'b1;
        if (rd_q[head] != '0) begin
          commit_addr <= rd_q[head];
          commit_data <= data_q[head];
        end
      end
      count <= count + CW'(alloc_acc) - CW'(retire);
    end
  end
endmodule

// File: tb/tb_commit_buffer.sv
// tb_commit_buffer: directed vectors with hand-computed expectations for commit_buffer
module tb_commit_buffer;
  logic        clk = 0, reset = 1;
  logic        alloc_valid = 0, alloc_ready;
  logic [3:0]  alloc_tag = 0, cdb_tag = 0;
  logic [4:0]  alloc_rd = 0, commit_addr;
  logic        cdb_valid = 0, commit_valid, empty, full;
  logic [31:0] cdb_data = 0, commit_data;
  logic [3:0]  count;
  int vectors = 0, miscompares = 0;

  commit_buffer #(.DEPTH(8), .TAG_W(4)) dut (
    .clk(clk), .reset(reset),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_addr(commit_addr), .commit_data(commit_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 0;
    cdb_valid = 0;
  endtask

  task automatic alloc(input logic [3:0] t, input logic [4:0] r);
    alloc_valid = 1; alloc_tag = t; alloc_rd = r;
    tick();
    alloc_valid = 0;
  endtask

  task automatic bcast(input logic [3:0] t, input logic [31:0] d);
    cdb_valid = 1; cdb_tag = t; cdb_data = d;
    tick();
    cdb_valid = 0;
  endtask

  task automatic commit_is(input string name, input logic v, input logic [4:0] a, input logic [31:0] d);
    chk({name, ".valid"}, 32'(commit_valid), 32'(v));
    if (v) begin
      chk({name, ".addr"}, 32'(commit_addr), 32'(a));
      chk({name, ".data"}, commit_data, d);
    end
  endtask

  initial begin
    tick(); tick();
    reset = 0;
    chk("rst.empty", 32'(empty), 1);
    chk("rst.count", 32'(count), 0);
    chk("rst.full", 32'(full), 0);
    chk("rst.alloc_ready", 32'(alloc_ready), 1);
    chk("rst.commit_valid", 32'(commit_valid), 0);
    chk("rst.commit_addr", 32'(commit_addr), 0);
    chk("rst.commit_data", commit_data, 0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle.commit_valid", 32'(commit_valid), 0);
      chk("idle.empty", 32'(empty), 1);
      chk("idle.count", 32'(count), 0);
      chk("idle.alloc_ready", 32'(alloc_ready), 1);
    end

    // single op
    alloc(3, 5);
    chk("single.count1", 32'(count), 1);
    chk("single.empty", 32'(empty), 0);
    bcast(3, 32'hAB);
    commit_is("single.capture", 0, 0, 0);
    tick();
    commit_is("single.commit", 1, 5, 32'hAB);
    chk("single.count0", 32'(count), 0);
    tick();
    chk("single.deassert", 32'(commit_valid), 0);
    chk("single.hold_addr", 32'(commit_addr), 5);
    chk("single.hold_data", commit_data, 32'hAB);

    // out-of-order completion, in-order retire
    alloc(1, 2); alloc(2, 4); alloc(3, 6);
    chk("ooo.count3", 32'(count), 3);
    bcast(3, 32'h30);
    commit_is("ooo.wait3", 0, 0, 0);
    bcast(2, 32'h20);
    commit_is("ooo.wait2", 0, 0, 0);
    bcast(1, 32'h10);
    commit_is("ooo.wait1", 0, 0, 0);
    tick(); commit_is("ooo.c0", 1, 2, 32'h10);
    tick(); commit_is("ooo.c1", 1, 4, 32'h20);
    tick(); commit_is("ooo.c2", 1, 6, 32'h30);
    chk("ooo.count0", 32'(count), 0);
    tick(); commit_is("ooo.done", 0, 0, 0);

    // full and wrap, from a fresh reset so tail starts at 0
    reset = 1; tick(); reset = 0;
    for (int i = 0; i < 8; i++) alloc(4'(i), 5'(8 + i));
    chk("full.full", 32'(full), 1);
    chk("full.alloc_ready", 32'(alloc_ready), 0);
    chk("full.count", 32'(count), 8);
    alloc(8, 20);
    chk("full.ignored_count", 32'(count), 8);
    for (int i = 0; i < 8; i++) begin
      cdb_valid = 1; cdb_tag = 4'(i); cdb_data = 32'h100 + 32'(i);
      if (i == 1) begin
        alloc_valid = 1; alloc_tag = 9; alloc_rd = 21;
        #1 chk("full.retire_no_alloc_ready", 32'(alloc_ready), 0);
      end
      tick();
      idle();
      chk("full.drain_count", 32'(count), 32'(8 - i));
      if (i == 0) commit_is("full.drain0", 0, 0, 0);
      else commit_is("full.drain", 1, 5'(8 + i - 1), 32'h100 + 32'(i - 1));
    end
    tick();
    commit_is("full.drain7", 1, 15, 32'h107);
    chk("full.empty", 32'(empty), 1);
    alloc(10, 1); alloc(11, 2); alloc(12, 3);
    chk("wrap.count", 32'(count), 3);
    bcast(10, 32'hA0); commit_is("wrap.w", 0, 0, 0);
    bcast(11, 32'hB0); commit_is("wrap.c0", 1, 1, 32'hA0);
    bcast(12, 32'hC0); commit_is("wrap.c1", 1, 2, 32'hB0);
    tick(); commit_is("wrap.c2", 1, 3, 32'hC0);
    chk("wrap.count0", 32'(count), 0);

    // tag reuse with stale same-cycle broadcast
    alloc(4, 9);
    bcast(4, 32'h11);
    alloc_valid = 1; alloc_tag = 4; alloc_rd = 10;
    cdb_valid = 1; cdb_tag = 4; cdb_data = 32'h99;
    tick(); idle();
    commit_is("reuse.old", 1, 9, 32'h11);
    chk("reuse.count", 32'(count), 1);
    tick(); commit_is("reuse.stale0", 0, 0, 0);
    tick(); commit_is("reuse.stale1", 0, 0, 0);
    chk("reuse.pending", 32'(count), 1);
    bcast(4, 32'h22); commit_is("reuse.cap", 0, 0, 0);
    tick(); commit_is("reuse.new", 1, 10, 32'h22);
    chk("reuse.count0", 32'(count), 0);

    // rd = 0 retires silently
    tick();
    alloc(5, 0); alloc(6, 7);
    bcast(5, 32'h55); commit_is("rd0.cap", 0, 0, 0);
    bcast(6, 32'h66); commit_is("rd0.silent", 0, 0, 0);
    chk("rd0.count1", 32'(count), 1);
    tick(); commit_is("rd0.rd7", 1, 7, 32'h66);
    tick(); commit_is("rd0.after", 0, 0, 0);
    chk("rd0.count0", 32'(count), 0);

    // reset with pending entries, head ready to retire
    alloc(1, 1); alloc(2, 2); alloc(3, 3);
    bcast(1, 32'h1);
    chk("midrst.count3", 32'(count), 3);
    reset = 1; tick(); reset = 0;
    chk("midrst.commit_valid", 32'(commit_valid), 0);
    chk("midrst.count", 32'(count), 0);
    chk("midrst.empty", 32'(empty), 1);
    chk("midrst.addr", 32'(commit_addr), 0);
    chk("midrst.data", commit_data, 0);
    bcast(2, 32'h2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("midrst.no_pulse", 32'(commit_valid), 0);
      chk("midrst.count_stays", 32'(count), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
